// File: rtl/golden_nonce_reporter_if.sv
// rtl/golden_nonce_reporter_if.sv - nonce input and UART/status outputs bundled for the reporter
interface golden_nonce_reporter_if #(
   parameter int FIFO_LOG2 = 2
);
   logic                 nonce_valid;
   logic [31:0]          nonce_in;
   logic                 uart_tx;
   logic                 busy;
   logic [FIFO_LOG2:0]   fifo_count;
   logic [7:0]           dropped_count;

   modport master (
      output nonce_valid, nonce_in,
      input  uart_tx, busy, fifo_count, dropped_count
   );

   modport slave (
      input  nonce_valid, nonce_in,
      output uart_tx, busy, fifo_count, dropped_count
   );
endinterface

// File: rtl/golden_nonce_reporter.sv
// rtl/golden_nonce_reporter.sv - queues golden nonces and sends each as four 8N1 bytes, MSB byte first
module golden_nonce_reporter #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_LOG2    = 2
) (
   input  logic                     hash_clk,
   input  logic                     reset,
   golden_nonce_reporter_if.slave   bus
);
   localparam int DEPTH = 1 << FIFO_LOG2;
   localparam int CNT_W = $clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0]     BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]     BIT_ONE    = 1;
   localparam logic [FIFO_LOG2-1:0] PTR_ONE    = 1;
   localparam logic [FIFO_LOG2:0]   CNT_ONE    = 1;
   localparam logic [FIFO_LOG2:0]   FULL_COUNT = (FIFO_LOG2 + 1)'(DEPTH);

   typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

   logic [31:0]          mem [DEPTH];
   logic [FIFO_LOG2-1:0] wr_ptr;
   logic [FIFO_LOG2-1:0] rd_ptr;
   logic [FIFO_LOG2:0]   count;
   logic [7:0]           dropped;

   state_t               state;
   logic [31:0]          shreg;
   logic [1:0]           byte_idx;
   logic [2:0]           bit_idx;
   logic [CNT_W-1:0]     bit_cnt;
   logic                 tx;

   logic                 pop;
   logic                 full;
   logic                 push_ok;
   logic [7:0]           cur_byte;

   // LOAD is the only popper; a pop in the same cycle frees room for a push even when full
   assign pop      = (state == LOAD);
   assign full     = (count == FULL_COUNT);
   assign push_ok  = bus.nonce_valid && (!full || pop);
   assign cur_byte = shreg[31:24];

   assign bus.uart_tx       = tx;
   assign bus.busy          = (state != IDLE);
   assign bus.fifo_count    = count;
   assign bus.dropped_count = dropped;

   // FIFO storage; contents need no reset because count gates every read
   always_ff @(posedge hash_clk) begin
      if (!reset && push_ok) begin
         mem[wr_ptr] <= bus.nonce_in;
      end
   end

   // FIFO pointers, occupancy and saturating drop counter
   always_ff @(posedge hash_clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         dropped <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push_ok, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         if (bus.nonce_valid && !push_ok && dropped != 8'hFF) begin
            dropped <= dropped + 8'd1;
         end
      end
   end

   // Transmit FSM; uart_tx is registered and set to the level of the state being entered
   always_ff @(posedge hash_clk) begin
      if (reset) begin
         state    <= IDLE;
         tx       <= 1'b1;
         shreg    <= '0;
         byte_idx <= '0;
         bit_idx  <= '0;
         bit_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (count != '0) begin
                  state <= LOAD;
               end
            end
            LOAD: begin
               shreg    <= mem[rd_ptr];
               byte_idx <= '0;
               bit_cnt  <= '0;
               tx       <= 1'b0;
               state    <= START;
            end
            START: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt <= '0;
                  bit_idx <= '0;
                  tx      <= cur_byte[0];
                  state   <= DATA;
               end else begin
                  bit_cnt <= bit_cnt + BIT_ONE;
               end
            end
            DATA: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= cur_byte[bit_idx + 3'd1];
                  end
               end else begin
                  bit_cnt <= bit_cnt + BIT_ONE;
               end
            end
            STOP: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt <= '0;
                  if (byte_idx == 2'd3) begin
                     state <= IDLE;
                  end else begin
                     byte_idx <= byte_idx + 2'd1;
                     shreg    <= {shreg[23:0], 8'h00};
                     tx       <= 1'b0;
                     state    <= START;
                  end
               end else begin
                  bit_cnt <= bit_cnt + BIT_ONE;
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_golden_nonce_reporter.sv
// tb/tb_golden_nonce_reporter.sv - directed checks of the golden nonce reporter at 4 clocks per bit
module tb_golden_nonce_reporter;
   localparam int CPB = 4;
   localparam int FL2 = 2;

   logic hash_clk = 1'b0;
   logic reset    = 1'b1;
   int   cyc      = 0;
   int   checks   = 0;
   int   errors   = 0;

   bit   tx_tr   [8192];
   bit   busy_tr [8192];

   golden_nonce_reporter_if #(.FIFO_LOG2(FL2)) bus ();

   golden_nonce_reporter #(.CLKS_PER_BIT(CPB), .FIFO_LOG2(FL2)) dut (
      .hash_clk (hash_clk),
      .reset    (reset),
      .bus      (bus)
   );

   always #5 hash_clk = ~hash_clk;

   // cyc counts rising edges; trace[k] holds outputs seen after edge k
   always @(posedge hash_clk) cyc <= cyc + 1;

   always @(negedge hash_clk) begin
      if (cyc < 8192) begin
         tx_tr[cyc]   = bus.uart_tx;
         busy_tr[cyc] = bus.busy;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge hash_clk);
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge hash_clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.nonce_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // push edge is the edge just before return, so cyc equals that edge on return
   task automatic push(input logic [31:0] v);
      bus.nonce_valid = 1'b1;
      bus.nonce_in    = v;
      tick();
      bus.nonce_valid = 1'b0;
      bus.nonce_in    = 32'hDEAD_BEEF;
   endtask

   // compare the 160-sample frame starting at trace index s against an ideal 8N1 waveform
   task automatic check_frame(input string tag, input int s, input logic [31:0] v);
      int         werr = 0;
      int         bcnt = 0;
      int         b;
      int         p;
      logic [7:0] byt;
      logic       e;
      logic [31:0] word = '0;
      for (int j = 0; j < 160; j++) begin
         b   = j / 40;
         p   = (j % 40) / 4;
         byt = 8'(v >> (24 - 8 * b));
         if (p == 0)      e = 1'b0;
         else if (p == 9) e = 1'b1;
         else             e = byt[p-1];
         if (tx_tr[s+j] != e) werr++;
         if (busy_tr[s+j]) bcnt++;
      end
      for (int bb = 0; bb < 4; bb++) begin
         for (int i = 0; i < 8; i++) begin
            word[24 - 8*bb + i] = tx_tr[s + 40*bb + 4*(1+i) + 2];
         end
      end
      check({tag, "_wave_err"}, werr, 0);
      check({tag, "_word"}, word, v);
      check({tag, "_busy_cycles"}, bcnt, 160);
      check({tag, "_pre_idle"}, tx_tr[s-1], 1'b1);
      check({tag, "_post"}, {tx_tr[s+160], busy_tr[s+160]}, 2'b10);
   endtask

   int n;
   int s;
   logic [31:0] vals [6];

   initial begin
      bus.nonce_valid = 1'b0;
      bus.nonce_in    = '0;
      do_reset();

      // reset state
      check("rst_tx", bus.uart_tx, 1'b1);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_count", bus.fifo_count, 0);
      check("rst_dropped", bus.dropped_count, 0);

      // single nonce: latency and full frame
      bus.nonce_in = 32'h5555_5555;
      tick();
      check("idle_no_valid", bus.fifo_count, 0);
      push(32'h1234_ABCD);
      n = cyc;
      check("lat_count1", {bus.fifo_count, bus.busy, bus.uart_tx}, {3'd1, 1'b0, 1'b1});
      tick();
      check("lat_load", {bus.fifo_count, bus.busy, bus.uart_tx}, {3'd1, 1'b1, 1'b1});
      tick();
      check("lat_start", {bus.fifo_count, bus.busy, bus.uart_tx}, {3'd0, 1'b1, 1'b0});
      wait_cyc(n + 166);
      check_frame("single", n + 2, 32'h1234_ABCD);
      check("single_end_count", bus.fifo_count, 0);

      // six consecutive pushes, then a push in the LOAD cycle with the FIFO full
      do_reset();
      vals[0] = 32'hA0A0_0001; vals[1] = 32'hB1B2_B3B4; vals[2] = 32'hC0FF_EE00;
      vals[3] = 32'h0F1E_2D3C; vals[4] = 32'h8001_7FFE; vals[5] = 32'hFFFF_0000;
      n = cyc + 1;
      for (int i = 0; i < 6; i++) begin
         bus.nonce_valid = 1'b1;
         bus.nonce_in    = vals[i];
         tick();
      end
      bus.nonce_valid = 1'b0;
      check("burst_count", bus.fifo_count, 4);
      check("burst_dropped", bus.dropped_count, 1);
      wait_cyc(n + 163);
      check("load_full_pre", {bus.fifo_count, bus.busy, bus.uart_tx}, {3'd4, 1'b1, 1'b1});
      bus.nonce_valid = 1'b1;
      bus.nonce_in    = 32'h6789_0123;
      tick();
      bus.nonce_valid = 1'b0;
      check("load_full_count", bus.fifo_count, 4);
      check("load_full_dropped", bus.dropped_count, 1);
      vals[5] = 32'h6789_0123;
      wait_cyc(n + 2 + 162*6 + 4);
      for (int k = 0; k < 6; k++) begin
         s = n + 2 + 162*k;
         check_frame($sformatf("burst%0d", k), s, vals[k]);
         if (k < 5) begin
            check($sformatf("gap%0d", k),
                  {tx_tr[s+160], tx_tr[s+161], busy_tr[s+160], busy_tr[s+161]}, 4'b1101);
         end
      end
      check("burst_end_count", bus.fifo_count, 0);

      // drop counter saturation
      do_reset();
      for (int i = 0; i < 300; i++) begin
         bus.nonce_valid = 1'b1;
         bus.nonce_in    = 32'(i);
         tick();
      end
      check("sat_dropped", bus.dropped_count, 8'hFF);
      check("sat_count", bus.fifo_count, 4);
      for (int i = 0; i < 5; i++) tick();
      bus.nonce_valid = 1'b0;
      check("sat_hold", bus.dropped_count, 8'hFF);

      // reset during DATA of the third byte, with valid held during reset
      do_reset();
      push(32'h1122_3344);
      n = cyc;
      push(32'h5566_7788);
      wait_cyc(n + 90);
      check("mid_busy", {bus.busy, bus.fifo_count}, {1'b1, 3'd1});
      reset = 1'b1;
      bus.nonce_valid = 1'b1;
      bus.nonce_in    = 32'hBAD0_BAD0;
      tick();
      check("abort_state", {bus.uart_tx, bus.busy, bus.fifo_count}, {1'b1, 1'b0, 3'd0});
      check("abort_dropped", bus.dropped_count, 0);
      tick();
      reset = 1'b0;
      bus.nonce_valid = 1'b0;
      check("rst_valid_ignored", {bus.fifo_count, bus.dropped_count}, {3'd0, 8'd0});
      tick();
      push(32'h9ABC_DEF0);
      n = cyc;
      wait_cyc(n + 166);
      check_frame("after_rst", n + 2, 32'h9ABC_DEF0);
      check("after_rst_count", bus.fifo_count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/golden_nonce_reporter.md
GOLDEN_NONCE_REPORTER -- requirements
Module: golden_nonce_reporter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, SHALL set hash_clk cycles per UART bit (legal range 2..65535).
REQ-002 Parameter FIFO_LOG2, default 2, SHALL set FIFO depth to 2**FIFO_LOG2 entries (legal range 1..4).
REQ-003 hash_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 nonce_valid  input  1  SHALL be a one-cycle pulse marking a golden nonce.
REQ-006 nonce_in  input  32  SHALL be the golden nonce, sampled only when nonce_valid=1.
REQ-007 uart_tx  output  1  SHALL be the 8N1 serial line, idle high.
REQ-008 busy  output  1  SHALL be 1 whenever the transmitter is not in IDLE.
REQ-009 fifo_count  output  FIFO_LOG2+1  SHALL be the current number of queued nonces.
REQ-010 dropped_count  output  8  SHALL count nonces lost to a full FIFO.

Function
REQ-011 FIFO SHALL store 32-bit nonces in arrival order; push on nonce_valid, pop on the transmitter LOAD.
REQ-012 Push when full without a same-cycle pop SHALL discard nonce_in, leave FIFO contents unchanged, and increment dropped_count.
REQ-013 dropped_count SHALL saturate at 8'hFF, never wrap.
REQ-014 Simultaneous push and pop SHALL succeed at any occupancy including full; fifo_count unchanged.
REQ-015 Read/write pointers SHALL wrap modulo 2**FIFO_LOG2 with no lost or duplicated entries.
REQ-016 Transmitter FSM states: IDLE, LOAD, START, DATA, STOP.
REQ-017 IDLE -> LOAD when fifo_count != 0; otherwise remain IDLE with uart_tx=1.
REQ-018 LOAD (one cycle) SHALL pop the head nonce into a 32-bit shift register, set byte index=0, then enter START.
REQ-019 START SHALL drive uart_tx=0 for exactly CLKS_PER_BIT cycles, then enter DATA.
REQ-020 DATA SHALL drive 8 bits of the current byte LSB-first, each for exactly CLKS_PER_BIT cycles, then enter STOP.
REQ-021 Byte order SHALL be most-significant first: nonce[31:24], [23:16], [15:8], [7:0].
REQ-022 STOP SHALL drive uart_tx=1 for exactly CLKS_PER_BIT cycles; then START for the next byte if byte index<3, else IDLE.
REQ-023 One nonce frame SHALL therefore occupy exactly 40*CLKS_PER_BIT cycles from START entry to IDLE re-entry.
REQ-024 Latency: push at edge N into an empty FIFO with FSM in IDLE SHALL make fifo_count=1 after N, LOAD after N+1, uart_tx=0 after N+2.
REQ-025 Back-to-back queued nonces SHALL start with one IDLE cycle and one LOAD cycle (uart_tx=1) between the last STOP and the next START.
REQ-026 Bit-period counter SHALL be wide enough for CLKS_PER_BIT-1 and reload at every bit boundary without drift.
REQ-027 nonce_in changes while nonce_valid=0 SHALL have no effect.

Reset
REQ-028 reset=1 at a rising edge SHALL force: FSM=IDLE, uart_tx=1, busy=0, fifo_count=0, pointers=0, dropped_count=0, bit counter=0.
REQ-029 reset mid-frame SHALL abort transmission immediately (uart_tx=1 after the reset edge) and discard all queued nonces.
REQ-030 nonce_valid asserted during reset SHALL be ignored (not queued, not counted as dropped).

Verification (CLKS_PER_BIT=4, FIFO_LOG2=2)
REQ-031 Single push 32'h1234ABCD into idle block -> uart_tx low 2 cycles after push edge; bytes 12,34,AB,CD decoded; 160 cycles of busy frame; fifo_count returns 0.
REQ-032 Six pushes on consecutive cycles while idle -> first popped at LOAD, 4 queued plus at most one accepted via concurrent pop; dropped_count=1, remaining nonces transmitted in order.
REQ-033 Push on the same cycle as LOAD with FIFO full -> fifo_count stays 4, dropped_count unchanged.
REQ-034 300 pushes against a full FIFO -> dropped_count=8'hFF, stays there.
REQ-035 reset asserted during DATA of byte 2 -> uart_tx=1, busy=0, fifo_count=0 after the reset edge; next push transmits cleanly.
REQ-036 Two nonces queued -> exactly 2 idle-high cycles (IDLE, LOAD) between frames; all 80 bit periods exactly 4 cycles.
